// File: rtl/alu_mdu_seq_if.sv
// Request/result bundle for alu_mdu_seq.
// The flush wire exists only when ALU_MDU_FLUSH_EN is defined.
interface alu_mdu_seq_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             carry;
    logic             negative;
    logic             overflow;
    logic             div_zero;
`ifdef ALU_MDU_FLUSH_EN
    logic             flush;

    modport master (
        output in_valid, op, a, b, flush,
        input  ready, out_valid, r, hi, zero, carry, negative, overflow, div_zero
    );
    modport slave (
        input  in_valid, op, a, b, flush,
        output ready, out_valid, r, hi, zero, carry, negative, overflow, div_zero
    );
`else
    modport master (
        output in_valid, op, a, b,
        input  ready, out_valid, r, hi, zero, carry, negative, overflow, div_zero
    );
    modport slave (
        input  in_valid, op, a, b,
        output ready, out_valid, r, hi, zero, carry, negative, overflow, div_zero
    );
`endif
endinterface

// File: rtl/alu_mdu_seq.sv
// Registered ALU with iterative multiply/divide and a HI register.
// Optional ALU_MDU_FLUSH_EN adds a flush input that aborts a running MD op.
module alu_mdu_seq #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    alu_mdu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

    state_t             state_q, state_d;
    logic [1:0]         md_op_q, md_op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, m_q, m_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   r_q, r_d, hi_q, hi_d;
    logic               zero_q, zero_d, carry_q, carry_d, negative_q, negative_d;
    logic               overflow_q, overflow_d, div_zero_q, div_zero_d;
    logic               out_valid_q, out_valid_d;

    logic flush, ready, accept, is_md, is_rsvd;

`ifdef ALU_MDU_FLUSH_EN
    assign flush = bus.flush;
`else
    assign flush = 1'b0;
`endif

    assign accept  = bus.in_valid && ready;
    assign is_md   = bus.op[4] && (bus.op[3:2] == 2'b00);
    assign is_rsvd = bus.op[4] && (bus.op[3:2] != 2'b00);

    // Single-cycle ALU evaluated on the live inputs so results land at the accept edge
    logic [WIDTH-1:0] alu_r;
    logic             alu_zero, alu_carry, alu_neg, alu_ovf;
    logic [WIDTH:0]   add_w, sub_w, sll_w, srl_w, sra_w;
    logic [SHW-1:0]   sh;
    logic             slt;

    always_comb begin
        sh        = bus.a[SHW-1:0];
        add_w     = {1'b0, bus.a} + {1'b0, bus.b};
        sub_w     = {1'b0, bus.a} - {1'b0, bus.b};
        sll_w     = {1'b0, bus.b} << sh;
        srl_w     = {bus.b, 1'b0} >> sh;
        sra_w     = $signed({bus.b, 1'b0}) >>> sh;
        slt       = $signed(bus.a) < $signed(bus.b);
        alu_r     = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (bus.op[3:0])
            4'b0000: begin alu_r = add_w[WIDTH-1:0]; alu_carry = add_w[WIDTH]; end
            4'b0010: begin
                alu_r   = add_w[WIDTH-1:0];
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_r[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b0001: begin alu_r = sub_w[WIDTH-1:0]; alu_carry = sub_w[WIDTH]; end
            4'b0011: begin
                alu_r   = sub_w[WIDTH-1:0];
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_r[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b0100: alu_r = bus.a & bus.b;
            4'b0101: alu_r = bus.a | bus.b;
            4'b0110: alu_r = bus.a ^ bus.b;
            4'b0111: alu_r = ~(bus.a | bus.b);
            4'b1000, 4'b1001: alu_r = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            4'b1011: alu_r = {{(WIDTH-1){1'b0}}, slt};
            4'b1010: begin alu_r = {{(WIDTH-1){1'b0}}, sub_w[WIDTH]}; alu_carry = sub_w[WIDTH]; end
            4'b1100: begin alu_r = sra_w[WIDTH:1]; alu_carry = sra_w[0]; end
            4'b1101: begin alu_r = srl_w[WIDTH:1]; alu_carry = srl_w[0]; end
            default: begin alu_r = sll_w[WIDTH-1:0]; alu_carry = sll_w[WIDTH]; end
        endcase
        alu_zero = (bus.op[3:1] == 3'b101) ? (bus.a == bus.b) : (alu_r == '0);
        alu_neg  = (bus.op[3:0] == 4'b1011) ? alu_r[0] : alu_r[WIDTH-1];
        if (is_rsvd) begin
            alu_r     = '0;
            alu_zero  = 1'b0;
            alu_carry = 1'b0;
            alu_neg   = 1'b0;
            alu_ovf   = 1'b0;
        end
    end

    // Operand magnitudes for the unsigned iterative core, and one iteration step
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_step, div_step;

    always_comb begin
        mag_a     = (!bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b     = (!bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
        mul_step  = {mul_sum, p_q[WIDTH-1:1]};
        div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m_q};
        div_step  = div_diff[WIDTH]
                  ? {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                  : {div_diff[WIDTH-1:0],  p_q[WIDTH-2:0], 1'b1};
    end

    // Sign correction of the finished magnitude result
    logic               sign_a, sign_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_r, fix_hi;
    logic               fix_ovf, fix_dz;

    always_comb begin
        sign_a  = !md_op_q[0] && a_q[WIDTH-1];
        sign_b  = !md_op_q[0] && b_q[WIDTH-1];
        prod    = (sign_a ^ sign_b) ? -p_q : p_q;
        fix_ovf = 1'b0;
        fix_dz  = 1'b0;
        if (!md_op_q[1]) begin
            fix_r  = prod[WIDTH-1:0];
            fix_hi = prod[2*WIDTH-1:WIDTH];
        end else if (b_q == '0) begin
            fix_r  = '1;
            fix_hi = a_q;
            fix_dz = 1'b1;
        end else begin
            fix_r   = (sign_a ^ sign_b) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
            fix_hi  = sign_a ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
            fix_ovf = !md_op_q[0] && (a_q == MOST_NEG) && (b_q == '1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_md) state_d = BUSY;
            BUSY:    if (flush) state_d = IDLE;
                     else if (cnt_q == SHW'(WIDTH-1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE) && !flush;
    end

    always_comb begin
        md_op_d     = md_op_q;
        a_d         = a_q;
        b_d         = b_q;
        m_d         = m_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        hi_d        = hi_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        negative_d  = negative_q;
        overflow_d  = overflow_q;
        div_zero_d  = div_zero_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                if (is_md) begin
                    md_op_d = bus.op[1:0];
                    a_d     = bus.a;
                    b_d     = bus.b;
                    m_d     = mag_b;
                    p_d     = {{WIDTH{1'b0}}, mag_a};
                    cnt_d   = '0;
                end else begin
                    r_d         = alu_r;
                    zero_d      = alu_zero;
                    carry_d     = alu_carry;
                    negative_d  = alu_neg;
                    overflow_d  = alu_ovf;
                    div_zero_d  = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            BUSY: if (!flush) begin
                cnt_d = cnt_q + 1'b1;
                p_d   = md_op_q[1] ? div_step : mul_step;
            end
            FIX: if (!flush) begin
                r_d         = fix_r;
                hi_d        = fix_hi;
                zero_d      = (fix_r == '0);
                carry_d     = 1'b0;
                negative_d  = fix_r[WIDTH-1];
                overflow_d  = fix_ovf;
                div_zero_d  = fix_dz;
                out_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_op_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            m_q         <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            r_q         <= '0;
            hi_q        <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            negative_q  <= 1'b0;
            overflow_q  <= 1'b0;
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            md_op_q     <= md_op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            m_q         <= m_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            hi_q        <= hi_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            negative_q  <= negative_d;
            overflow_q  <= overflow_d;
            div_zero_q  <= div_zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.ready     = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.r         = r_q;
    assign bus.hi        = hi_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.negative  = negative_q;
    assign bus.overflow  = overflow_q;
    assign bus.div_zero  = div_zero_q;
endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
Parametrised, registered successor of the combinational MIPS-style ALU. It keeps the same 4-bit single-cycle operation set and adds iterative multiply and divide (signed and unsigned) behind a valid/ready handshake. A HI register holds the high word or remainder. It sits between the register-file read stage and writeback of the multi-cycle CPU datapath.

Parameters:
WIDTH, 32, datapath width; must be a power of 2 and at least 8; SHW = log2(WIDTH) is a localparam.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operation request
ready  out  1  block can accept a request
op  in  5  op[4]=0: ALU op in op[3:0] (encoding below); op[4]=1: 10000 MULT, 10001 MULTU, 10010 DIV, 10011 DIVU; 101xx/11xxx reserved
a  in  WIDTH  operand A (shift amount in a[SHW-1:0] for shifts)
b  in  WIDTH  operand B
out_valid  out  1  one-cycle result strobe
r  out  WIDTH  ALU result, or product low word / quotient
hi  out  WIDTH  product high word / remainder
zero, carry, negative, overflow  out  1 each  registered flags
div_zero  out  1  divide by zero flagged

Behaviour:
- ALU op[3:0] encoding:
  - 0000 ADDU, 0010 ADD, 0001 SUBU, 0011 SUB
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR
  - 100x LUI: r = {b[WIDTH/2-1:0], zeros}
  - 1011 SLT, 1010 SLTU
  - 1100 SRA, 1101 SRL, 111x SLL
- Reset: state IDLE; ready=1; out_valid=0; r, hi, all flags = 0. Reset mid-operation discards the operation with no out_valid.
- Accept: a request is taken at the clk edge where in_valid && ready. Operands and op are latched at that edge; later input changes are ignored.
- States:
  - IDLE: ALU op accepted → outputs written at the same edge, out_valid=1 in the next cycle, stay IDLE (1-cycle latency, ready stays 1, back-to-back allowed). MD op accepted → BUSY, ready=0.
  - BUSY: WIDTH iterations, one per cycle (shift-add multiply / restoring divide on magnitudes). After the WIDTH-th iteration → FIX.
  - FIX: sign correction, then write r/hi/flags; out_valid=1 the next cycle; → IDLE. MD latency is WIDTH+2 cycles from the accept edge to out_valid high.
- out_valid is high exactly one cycle per accepted request. It may coincide with a new accept.
- Flags (all flags written on every result; a flag not defined for the op is 0):
  - zero = (r==0), except SLT/SLTU where zero = (a==b).
  - negative = r[WIDTH-1], except SLT where negative = r[0].
  - carry:
    - ADDU: unsigned carry out.
    - SUBU/SLTU: a<b unsigned.
    - Shifts: last bit shifted out of b; 0 when the amount is 0.
  - overflow: ADD/SUB signed overflow; DIV of the most-negative value by -1.
- hi is written only by MD ops and holds its value across ALU ops.
- Signed multiply: r/hi = low/high halves of the 2*WIDTH-bit two's-complement product.
- Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
- Most-negative / -1: r = most-negative, hi = 0, overflow = 1.
- Divide by zero (both signed and unsigned):
  - r = all ones, hi = a, div_zero = 1.
  - Full latency is still taken.
  - div_zero = 0 for every other result.
- Reserved op: treated as an ALU op with r=0 and all flags 0; out_valid is still produced.

Optional Feature:
ALU_MDU_FLUSH_EN
- Defined: adds input port flush (1 bit). flush=1 in BUSY or FIX returns to IDLE at the next edge with no out_valid; r, hi and flags are unchanged. flush in IDLE has no effect, and an in_valid in the same cycle as flush is not accepted (ready forced to 0 while flush=1).
- Undefined: no flush port; MD ops always run to completion.

Test Plan:
- WIDTH=32, ADD a=0x7FFFFFFF b=1 → next cycle out_valid=1, r=0x80000000, overflow=1, negative=1, zero=0, carry=0.
- MULT a=0xFFFFFFFD (-3) b=5 → ready=0 for 33 cycles, out_valid at accept+34, r=0xFFFFFFF1, hi=0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7) b=2 → r=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=0x1234 b=0 → r=0xFFFFFFFF, hi=0x1234, div_zero=1.
- SRA a=4 b=0x80000010 → r=0xF8000001, carry=0. SLL a=1 b=0x80000000 → r=0, carry=1, zero=1.
- Back-to-back ADDU/ALU ops on consecutive cycles → one out_valid per op in order. DIVU of 0x80000000 by -1 in signed DIV → r=0x80000000, hi=0, overflow=1.
- rst pulsed 10 cycles into a MULTU → immediately ready=1, out_valid=0, r=hi=0. With ALU_MDU_FLUSH_EN, flush during BUSY → IDLE next edge, no out_valid, prior r retained.
